// File: rtl/l2_data_array.sv
// Byte-maskable L2 data array with a power-up/clear zeroing sweep and a 1-cycle registered
// read port; read and load share one index, and a same-cycle read returns the merged data.
module l2_data_array #(
  parameter int unsigned s_index  = 3,
  parameter int unsigned width    = 256,
  parameter int unsigned num_sets = 2**s_index
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 read,
  input  logic                 load,
  input  logic [s_index-1:0]   index,
  input  logic [width-1:0]     datain,
  input  logic [width/8-1:0]   byte_en,
  input  logic                 clear,
  output logic                 ready,
  output logic                 rvalid,
  output logic [width-1:0]     dataout
);

  localparam int NumBytes = width / 8;
  localparam logic [s_index-1:0] LastIdx = s_index'(num_sets - 1);
  localparam logic [s_index-1:0] CtrOne  = s_index'(1);

  typedef enum logic {StInit, StIdle} state_e;

  state_e               r_state;
  logic [s_index-1:0]   r_ctr;
  logic                 r_rvalid;
  logic [width-1:0]     r_dataout;
  logic [width-1:0]     r_data [num_sets];

  logic [width-1:0]     w_merged;
  logic                 w_acc_load;
  logic                 w_acc_read;

  assign w_acc_load = (r_state == StIdle) && !clear && load;
  assign w_acc_read = (r_state == StIdle) && !clear && read;

  // Stored entry with enabled bytes replaced; doubles as the write-first read value.
  always_comb begin
    w_merged = r_data[index];
    for (int b = 0; b < NumBytes; b++) begin
      if (byte_en[b]) begin
        w_merged[8*b +: 8] = datain[8*b +: 8];
      end
    end
  end

  // Storage carries no reset; the sweep is what defines its contents.
  always_ff @(posedge clk) begin
    if (r_state == StInit) begin
      r_data[r_ctr] <= '0;
    end else if (w_acc_load) begin
      r_data[index] <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StInit;
      r_ctr     <= '0;
      r_rvalid  <= 1'b0;
      r_dataout <= '0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        StInit: begin
          if (r_ctr == LastIdx) begin
            r_state <= StIdle;
            r_ctr   <= '0;
          end else begin
            r_ctr <= r_ctr + CtrOne;
          end
        end
        StIdle: begin
          if (clear) begin
            r_state <= StInit;
            r_ctr   <= '0;
          end else if (w_acc_read) begin
            r_rvalid  <= 1'b1;
            r_dataout <= load ? w_merged : r_data[index];
          end
        end
      endcase
    end
  end

  assign ready   = (r_state == StIdle);
  assign rvalid  = r_rvalid;
  assign dataout = r_dataout;

endmodule

// File: tb/tb_l2_data_array.sv
// Bench for l2_data_array: directed scenarios plus random traffic against an array-level model.
module tb_l2_data_array;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read;
  logic        load;
  logic        clear;
  logic [2:0]  index;
  logic [31:0] datain;
  logic [3:0]  byte_en;
  logic        ready;
  logic        rvalid;
  logic [31:0] dataout;

  l2_data_array #(
    .s_index  (3),
    .width    (32),
    .num_sets (8)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .read    (read),
    .load    (load),
    .index   (index),
    .datain  (datain),
    .byte_en (byte_en),
    .clear   (clear),
    .ready   (ready),
    .rvalid  (rvalid),
    .dataout (dataout)
  );

  always #5 clk = ~clk;

  // Reference model: contents, cycles of sweep still to run, expected read port.
  logic [31:0] mem [N];
  int          init_left;
  logic        exp_rvalid;
  logic [31:0] exp_dout;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic zero_mem();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then compare after the edge.
  task automatic step(input logic rd, input logic ld, input logic [2:0] idx,
                      input logic [31:0] din, input logic [3:0] be, input logic clr);
    read    = rd;
    load    = ld;
    index   = idx;
    datain  = din;
    byte_en = be;
    clear   = clr;
    exp_rvalid = 1'b0;
    if (init_left > 0) begin
      init_left--;
    end else if (clr) begin
      init_left = N;
      zero_mem();
    end else begin
      if (ld) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] = din[8*b +: 8];
        end
      end
      if (rd) begin
        exp_rvalid = 1'b1;
        exp_dout   = mem[idx];
      end
    end
    @(posedge clk);
    #1;
    check("ready", 32'(ready), 32'(init_left == 0));
    check("rvalid", 32'(rvalid), 32'(exp_rvalid));
    check("dataout", dataout, exp_dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_dataout", dataout, 32'h0);
    init_left  = N;
    exp_rvalid = 1'b0;
    exp_dout   = '0;
    zero_mem();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    read = 1'b0; load = 1'b0; clear = 1'b0;
    index = '0; datain = '0; byte_en = '0;
    zero_mem();
    init_left  = N;
    exp_rvalid = 1'b0;
    exp_dout   = '0;
    do_reset();

    // Power-up sweep, then every entry reads zero.
    idle(N);
    check("ready_after_sweep", 32'(ready), 32'h1);
    for (int i = 0; i < N; i++) step(1'b1, 1'b0, 3'(i), 32'h0, 4'h0, 1'b0);

    // Byte-masked overwrite.
    step(1'b0, 1'b1, 3'd2, 32'hAABBCCDD, 4'b1111, 1'b0);
    step(1'b0, 1'b1, 3'd2, 32'h11223344, 4'b0101, 1'b0);
    step(1'b1, 1'b0, 3'd2, 32'h0, 4'h0, 1'b0);
    check("masked_write", dataout, 32'hAA22CC44);

    // Write-first on same-cycle read and load.
    step(1'b0, 1'b1, 3'd5, 32'h01020304, 4'b1111, 1'b0);
    step(1'b1, 1'b1, 3'd5, 32'hFFFFFFFF, 4'b0011, 1'b0);
    check("write_first", dataout, 32'h0102FFFF);
    idle(1);
    step(1'b1, 1'b0, 3'd5, 32'h0, 4'h0, 1'b0);
    check("write_first_kept", dataout, 32'h0102FFFF);

    // Back-to-back reads.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'(i), 32'h10 + 32'(i), 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 3'(i), 32'h0, 4'h0, 1'b0);
      check("b2b_data", dataout, 32'h10 + 32'(i));
    end

    // Clear with a concurrent read; loads and repeated clears during the sweep are ignored.
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, 3'(i), 32'hC0DE0000 + 32'(i), 4'hF, 1'b0);
    step(1'b1, 1'b0, 3'd3, 32'h0, 4'h0, 1'b1);
    check("clear_no_rvalid", 32'(rvalid), 32'h0);
    step(1'b0, 1'b1, 3'd4, 32'hDEADBEEF, 4'hF, 1'b0);
    step(1'b1, 1'b0, 3'd4, 32'h0, 4'h0, 1'b1);
    idle(N - 2);
    for (int i = 0; i < N; i++) step(1'b1, 1'b0, 3'(i), 32'h0, 4'h0, 1'b0);

    // Reset in the middle of a clear sweep.
    step(1'b0, 1'b1, 3'd1, 32'h12345678, 4'hF, 1'b0);
    step(1'b1, 1'b0, 3'd1, 32'h0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b1);
    idle(4);
    do_reset();
    idle(N - 1);
    check("reset_sweep_not_done", 32'(ready), 32'h0);
    idle(1);
    check("reset_sweep_done", 32'(ready), 32'h1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           32'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 29) == 0));
    end
    idle(N);
    for (int i = 0; i < N; i++) step(1'b1, 1'b0, 3'(i), 32'h0, 4'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
